// File: rtl/tt_mux_pkg.sv
// Shared definitions for the project multiplexer and its select controller.
package tt_mux_pkg;

    // Defaults shared with the mux so both sides agree on the address space.
    localparam int MUX_NUM_PROJECTS = 24;
    localparam int MUX_ADDR_W       = 5;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } mux_state_t;

endpackage

// File: rtl/mux_sel_ctrl_pin_sync.sv
// Multi-stage synchronizer for one slow asynchronous pin, with an optional
// rising-edge strobe built from the synchronized level.
module pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[SYNC_STAGES-2:0], pin};
    end

    assign sync = chain[SYNC_STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic sync_q;

            // Delay the synchronized level one cycle for edge detection.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= 1'b0;
                else     sync_q <= sync;
            end

            assign rise = sync & ~sync_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mux_sel_ctrl.sv
// Project-mux select controller: synchronizes the clear/increment/enable
// pins, sequences the project address and gates the enable with a
// break-before-make guard so no project is enabled while addr settles.
//
//   state | meaning
//   OFF   | no project enabled, waiting for an enable request
//   GUARD | address settling; ena held low until gcnt expires quietly
//   ON    | selected project enabled
module mux_sel_ctrl
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJECTS = MUX_NUM_PROJECTS,
    parameter int ADDR_W       = MUX_ADDR_W,
    parameter int GUARD_CYCLES = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_clr,
    input  logic              sel_inc,
    input  logic              sel_ena,
    output logic [ADDR_W-1:0] addr,
    output logic              ena,
    output logic              busy
);

    localparam int                GCNT_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [GCNT_W-1:0] GCNT_LOAD = GCNT_W'(GUARD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PROJECTS - 1);

    logic s_clr, s_inc, s_ena;
    logic inc_pulse;
    logic clr_rise_unused, ena_rise_unused;
    logic change;

    mux_state_t        state;
    logic [GCNT_W-1:0] gcnt;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_clr (
        .clk  (clk),
        .rst  (rst),
        .pin  (sel_clr),
        .sync (s_clr),
        .rise (clr_rise_unused)
    );

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_inc (
        .clk  (clk),
        .rst  (rst),
        .pin  (sel_inc),
        .sync (s_inc),
        .rise (inc_pulse)
    );

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_ena (
        .clk  (clk),
        .rst  (rst),
        .pin  (sel_ena),
        .sync (s_ena),
        .rise (ena_rise_unused)
    );

    // A held clear counts as a change every cycle so the guard never expires under it.
    assign change = s_clr | inc_pulse;

    // Address register: clear beats increment, increment wraps below NUM_PROJECTS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (s_clr) begin
            addr <= '0;
        end else if (inc_pulse) begin
            addr <= (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);
        end
    end

    // Enable sequencer; ena drops on the same edge that moves addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            gcnt  <= '0;
            ena   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (s_ena) begin
                        state <= ST_GUARD;
                        gcnt  <= GCNT_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (!s_ena) begin
                        state <= ST_OFF;
                        busy  <= 1'b0;
                    end else if (change) begin
                        gcnt <= GCNT_LOAD;
                    end else if (gcnt == '0) begin
                        state <= ST_ON;
                        busy  <= 1'b0;
                        ena   <= 1'b1;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                ST_ON: begin
                    if (!s_ena) begin
                        state <= ST_OFF;
                        ena   <= 1'b0;
                    end else if (change) begin
                        state <= ST_GUARD;
                        gcnt  <= GCNT_LOAD;
                        ena   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    ena   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Bench for mux_sel_ctrl. Reference model works on pin-sample history windows:
// a pin sampled at edge t acts at edge t+SS; ena is expected high after an
// edge when the synchronized enable has been high for the last G+1 edges and
// no address change occurred in the last G edges.
module tb_mux_sel_ctrl;

    localparam int N  = 24;
    localparam int AW = 5;
    localparam int G  = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel_clr, sel_inc, sel_ena;
    logic [AW-1:0] addr;
    logic          ena, busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // model state
    bit h_clr [0:SS+1];
    bit h_inc [0:SS+1];
    bit h_ena [0:SS+1];
    int m_addr, ena_run, quiet;
    bit m_ena, m_busy;

    mux_sel_ctrl #(
        .NUM_PROJECTS (N),
        .ADDR_W       (AW),
        .GUARD_CYCLES (G),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sel_clr (sel_clr),
        .sel_inc (sel_inc),
        .sel_ena (sel_ena),
        .addr    (addr),
        .ena     (ena),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i <= SS + 1; i++) begin
            h_clr[i] = 1'b0;
            h_inc[i] = 1'b0;
            h_ena[i] = 1'b0;
        end
        m_addr  = 0;
        ena_run = 0;
        quiet   = 0;
        m_ena   = 1'b0;
        m_busy  = 1'b0;
    endtask

    task automatic model_edge();
        bit c, p, e;
        for (int i = SS + 1; i > 0; i--) begin
            h_clr[i] = h_clr[i-1];
            h_inc[i] = h_inc[i-1];
            h_ena[i] = h_ena[i-1];
        end
        h_clr[0] = sel_clr;
        h_inc[0] = sel_inc;
        h_ena[0] = sel_ena;
        c = h_clr[SS];
        p = h_inc[SS] & ~h_inc[SS+1];
        e = h_ena[SS];
        if (c)      m_addr = 0;
        else if (p) m_addr = (m_addr + 1) % N;
        ena_run = e ? ((ena_run < 1000) ? ena_run + 1 : ena_run) : 0;
        quiet   = (c | p) ? 0 : ((quiet < 1000) ? quiet + 1 : quiet);
        m_ena   = (ena_run >= G + 1) && (quiet >= G);
        m_busy  = e && !m_ena;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("model_addr", 32'(addr), 32'(m_addr));
        chk("model_ena",  32'(ena),  32'(m_ena));
        chk("model_busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic inc_pulse();
        sel_inc = 1'b1;
        steps(2);
        sel_inc = 1'b0;
        steps(2);
    endtask

    initial begin
        rst = 1'b1; sel_clr = 1'b0; sel_inc = 1'b0; sel_ena = 1'b0;
        model_reset();
        #3;
        chk("reset_addr", 32'(addr), 0);
        chk("reset_ena",  32'(ena),  0);
        chk("reset_busy", 32'(busy), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // stays off without an enable request
        steps(3);
        chk("idle_busy", 32'(busy), 0);

        // enable latency: sampled at edge k, busy from k+2, ena at k+6
        sel_ena = 1'b1;
        step(); chk("lat_busy_k",  32'(busy), 0);
        step(); chk("lat_busy_k1", 32'(busy), 0);
        step(); chk("lat_busy_k2", 32'(busy), 1);
        steps(2);
        step(); chk("lat_ena_k5", 32'(ena), 0);
        step(); chk("lat_ena_k6", 32'(ena), 1);

        // walk up to address 22
        for (int i = 0; i < 22; i++) inc_pulse();
        steps(G + 2);
        chk("at22_addr", 32'(addr), 22);
        chk("at22_ena",  32'(ena),  1);

        // two clean increments: 23 then wrap to 0
        for (int j = 0; j < 2; j++) begin
            sel_inc = 1'b1;
            steps(2);
            step();
            chk("wrap_addr", 32'(addr), (j == 0) ? 23 : 0);
            chk("wrap_ena_drop", 32'(ena), 0);
            sel_inc = 1'b0;
            steps(3);
            chk("wrap_ena_guard", 32'(ena), 0);
            step();
            chk("wrap_ena_back", 32'(ena), 1);
        end

        // held increment advances once only
        sel_inc = 1'b1;
        steps(20);
        sel_inc = 1'b0;
        steps(6);
        chk("held_inc_addr", 32'(addr), 1);
        chk("held_inc_ena",  32'(ena),  1);

        // reach address 7
        for (int i = 0; i < 6; i++) inc_pulse();
        steps(6);
        chk("at7_addr", 32'(addr), 7);

        // clear and increment together: clear wins, guard held while clear high
        sel_clr = 1'b1;
        sel_inc = 1'b1;
        steps(2);
        step();
        chk("clr_prio_addr", 32'(addr), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("clr_hold_busy", 32'(busy), 1);
            chk("clr_hold_addr", 32'(addr), 0);
        end
        sel_clr = 1'b0;
        sel_inc = 1'b0;
        steps(8);
        chk("clr_after_ena", 32'(ena), 1);

        // guard restart: second change lands while gcnt==1
        sel_inc = 1'b1; step();
        sel_inc = 1'b0; step(); step();
        sel_inc = 1'b1; step();
        sel_inc = 1'b0; step(); step();
        chk("restart_addr", 32'(addr), 2);
        step(); chk("restart_ena_a6", 32'(ena), 0);
        step(); chk("restart_ena_a7", 32'(ena), 0);
        step(); chk("restart_ena_a8", 32'(ena), 0);
        step(); chk("restart_ena_a9", 32'(ena), 1);

        // disable from ON
        sel_ena = 1'b0;
        step(); chk("dis_on_k",  32'(ena), 1);
        step(); chk("dis_on_k1", 32'(ena), 1);
        step(); chk("dis_on_k2", 32'(ena), 0);
        chk("dis_on_addr", 32'(addr), 2);

        // disable from GUARD: ena never pulses
        sel_ena = 1'b1;
        steps(4);
        chk("dis_guard_busy", 32'(busy), 1);
        sel_ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("dis_guard_ena", 32'(ena), 0);
        end

        // async reset mid-guard with random pins
        sel_ena = 1'b1;
        steps(4);
        chk("pre_rst_busy", 32'(busy), 1);
        #2;
        sel_clr = 1'($urandom_range(0, 1));
        sel_inc = 1'($urandom_range(0, 1));
        sel_ena = 1'($urandom_range(0, 1));
        rst = 1'b1;
        #1;
        chk("async_rst_addr", 32'(addr), 0);
        chk("async_rst_ena",  32'(ena),  0);
        chk("async_rst_busy", 32'(busy), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_busy", 32'(busy), 0);
        @(negedge clk);
        sel_ena = 1'b0;
        sel_clr = 1'b0;
        rst = 1'b0;
        steps(3);
        chk("post_rst_off", 32'(busy), 0);

        // randomized traffic against the window model
        sel_ena = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) sel_ena = ~sel_ena;
            if ($urandom_range(0, 3) == 0)  sel_inc = ~sel_inc;
            sel_clr = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
